// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
// FSM encoding, default address map and SRAM bus widths.
package arm_mem_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned SRAM_AW_DEF   = 18;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Splits a 32-bit pipeline load/store into two 16-bit async-SRAM accesses.
// ready rises 2*ACCESS_CYCLES+1 cycles after a request; ready=0 stalls upstream.
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = BASE_ADDR_DEF,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        Alu_Res,
  input  logic [31:0]        Val_Rm,
  output logic [31:0]        DataMem_out,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(ACCESS_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;

  logic               req;
  logic               busy;
  logic [31:0]        offs;
  logic [SRAM_AW-2:0] word;
  logic               addr_unused;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign busy = (state_q == S_LOW) || (state_q == S_HIGH);

  // Word bits above the SRAM size are dropped, so out-of-range addresses wrap.
  assign offs        = Alu_Res - 32'(BASE_ADDR);
  assign word        = offs[SRAM_AW:2];
  assign addr_unused = ^{offs[31:SRAM_AW+1], offs[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = CNT_RELOAD;
          wr_d    = MEM_W_EN;
          if (MEM_W_EN) wdata_d = Val_Rm;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = CNT_RELOAD;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = CNT_RELOAD;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign ready       = ~req | (state_q == S_DONE);
  assign DataMem_out = rdata_q;

  // Reset forces IDLE asynchronously, so the strobes and bus release at once.
  assign SRAM_CE_N = ~busy;
  assign SRAM_UB_N = ~busy;
  assign SRAM_LB_N = ~busy;
  assign SRAM_WE_N = ~(busy & wr_q);
  assign SRAM_OE_N = ~(busy & ~wr_q);

  always_comb begin
    SRAM_ADDR = '0;
    if (state_q == S_LOW)  SRAM_ADDR = {word, 1'b0};
    if (state_q == S_HIGH) SRAM_ADDR = {word, 1'b1};
  end

  assign SRAM_DQ = (busy && wr_q) ? ((state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                                  : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized bench for mem_sram_ctrl against a word-level memory model
// plus an async SRAM behavioural model on the pins.
module tb_mem_sram_ctrl;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AC   = 2;
  localparam int unsigned AW   = 18;
  localparam int LAT = 2 * AC + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MEM_R_EN = 1'b0;
  logic          MEM_W_EN = 1'b0;
  logic [31:0]   Alu_Res = '0;
  logic [31:0]   Val_Rm = '0;
  logic [31:0]   DataMem_out;
  logic          ready;
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, oe_n, ce_n, ub_n, lb_n;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] sram [0:(1<<AW)-1];
  logic [31:0] model_mem [int];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst_n), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .Alu_Res(Alu_Res), .Val_Rm(Val_Rm), .DataMem_out(DataMem_out), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Async SRAM: drives the bus while selected for read, stores while write-enabled.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) sram[sram_addr] <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_strb"}, {27'd0, ce_n, ub_n, lb_n, we_n, oe_n}, 32'h1f);
    check({tag, "_dq"}, {16'h0, sram_dq}, 32'h0000_zzzz);
    check({tag, "_addr"}, 32'(sram_addr), 32'h0);
  endtask

  // Starts at posedge+1 with the FSM idle; returns at posedge+1 after DONE.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] wd;
    int  cyc;
    bit  done;
    bit  hi;
    wd = 17'((a - BASE) >> 2);
    MEM_R_EN = r; MEM_W_EN = w; Alu_Res = a; Val_Rm = d;
    cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 2 * AC) begin
        hi = (cyc > AC);
        check("busy_ce", {29'd0, ce_n, ub_n, lb_n}, 32'h0);
        check("busy_we", 32'(we_n), 32'(!w));
        check("busy_oe", 32'(oe_n), 32'(w));
        check("busy_addr", 32'(sram_addr), 32'({wd, hi}));
        if (w) check("busy_dq", {16'h0, sram_dq}, {16'h0, hi ? d[31:16] : d[15:0]});
      end else begin
        check_idle_pins("edge");
      end
      if (ready) done = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("latency", cyc, LAT);
    if (w) model_mem[int'(wd)] = d;
    else if (r) exp_rd = model_mem.exists(int'(wd)) ? model_mem[int'(wd)] : 32'h0;
    check("rdata", DataMem_out, exp_rd);
    @(posedge clk); #1;
    MEM_R_EN = 0; MEM_W_EN = 0;
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;

    // Reset with no request
    #12;
    check("rst_ready", 32'(ready), 32'h1);
    check_idle_pins("rst");
    check("rst_rdata", DataMem_out, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'h1);
    check_idle_pins("idle");
    check("idle_rdata", DataMem_out, 32'h0);
    @(posedge clk); #1;

    // Directed store/load sequences
    access(0, 1, 32'd1024, 32'hDEADBEEF);
    access(1, 0, 32'd1024, 32'h0);
    access(0, 1, 32'd1028, 32'h12345678);
    access(1, 0, 32'd1024, 32'h0);
    access(1, 0, 32'd1028, 32'h0);
    access(1, 1, 32'd1032, 32'hCAFEF00D);
    access(1, 0, 32'd1032, 32'h0);

    // Reset asserted in cycle 3 of a load from 1024
    MEM_R_EN = 1; Alu_Res = 32'd1024;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_pins("midrst");
    check("midrst_ready", 32'(ready), 32'h0);
    check("midrst_rdata", DataMem_out, 32'h0);
    exp_rd = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1, 0, 32'd1024, 32'h0);

    // Randomized traffic, including wrapping addresses and idle gaps
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      if (k == 0) a = a + ($urandom << 19);
      if (k == 1) a = BASE - ($urandom_range(1, 8) << 2);
      d = $urandom;
      if (k == 2) begin
        @(negedge clk);
        check("gap_ready", 32'(ready), 32'h1);
        check("gap_rdata", DataMem_out, exp_rd);
        @(posedge clk); #1;
      end else if (k == 3) access(1, 1, a, d);
      else if ($urandom_range(0, 1) == 1) access(0, 1, a, d);
      else access(1, 0, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
